sw_stream_scheduler: RTL and testbench
======================================

// Module: sw_stream_scheduler
// PURPOSE
//  Sequences database reads into the ScoringModule systolic array: accepts a valid/ready base stream,
//  drives en_in/data_in/counter_in, inserts inter-sequence gaps, and returns each result tagged with
//  sequence ID and length. Credit-limits sequences in flight so an array result is never lost.
// PARAMETERS
//  SCORE_WIDTH  12                    array score width (bits)
//  CNT_WIDTH    12                    width of arr_counter and sequence length
//  ID_WIDTH     8                     sequence tag width; wraps modulo 2^ID_WIDTH
//  RES_DEPTH    4                     result FIFO depth = max sequences in flight (power of 2, >=2)
//  GAP_CYCLES   1                     idle cycles forced on arr_en after each sequence's last base (>=1)
//  ZERO         2**(SCORE_WIDTH-1)    biased zero of the array score
// PORTS
//  clk          in   1            clock, all logic on rising edge
//  rst          in   1            asynchronous, active-high reset
//  s_base       in   2            base code (A=00 G=01 T=10 C=11)
//  s_last       in   1            marks final base of a database sequence
//  s_valid      in   1            base valid
//  s_ready      out  1            base accepted when s_valid&s_ready
//  arr_en       out  1            to ScoringModule en_in
//  arr_data     out  2            to ScoringModule data_in
//  arr_counter  out  CNT_WIDTH    to ScoringModule counter_in: 0-based base index within sequence
//  arr_vld      in   1            ScoringModule vld
//  arr_result   in   SCORE_WIDTH  ScoringModule result (signed, biased)
//  r_valid      out  1            result available
//  r_ready      in   1            result consumed when r_valid&r_ready
//  r_score      out  SCORE_WIDTH  unsigned score = arr_result + ZERO (mod 2^SCORE_WIDTH)
//  r_id         out  ID_WIDTH     sequence tag, 0 for first sequence after reset
//  r_len        out  CNT_WIDTH    number of bases in the sequence
//  busy         out  1            any sequence streaming or in flight
//  err          out  1            sticky: arr_vld with no sequence in flight
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, credits=RES_DEPTH, next_id=0, FIFOs empty, err=0.
//  - FSM IDLE: s_ready=(credits>0). Accepting a base consumes one credit -> STREAM (or GAP if s_last).
//  - STREAM: s_ready=1; each accepted base increments index; s_last -> GAP.
//  - GAP: s_ready=0 for GAP_CYCLES cycles -> IDLE.
//  - Drive: accepted base appears on arr_data with arr_en=1 the next cycle (1-cycle latency);
//    arr_counter = index of that base; arr_en=0 on any cycle without acceptance. Index saturates at
//    2^CNT_WIDTH-1; r_len saturates likewise.
//  - On accepting s_last: push {next_id, len} into meta FIFO (depth RES_DEPTH); next_id++.
//  - On arr_vld: pop meta FIFO, push {arr_result+ZERO, id, len} into result FIFO. If meta FIFO is
//    empty: set err, push nothing. arr_vld never stalls; credits guarantee result FIFO has space.
//  - Credit returned on result pop (r_valid&r_ready). Same-cycle consume and return: net 0.
//  - r_* driven from result FIFO head; r_valid = FIFO non-empty; order = sequence order.
//  - Single-base sequence (s_last on first base) legal: IDLE -> GAP directly, len=1.
//  - s_valid low mid-sequence: arr_en drops, index held; array sees a bubble (allowed).
//  - busy = (FSM!=IDLE) | (credits!=RES_DEPTH).
//  - rst mid-sequence: everything cleared immediately; in-flight results are discarded.
// STRUCTURE
//  - Shared package sw_pkg: base_t enum (A,G,T,C codes), SCORE_WIDTH/ZERO defaults,
//    sched_state_t {IDLE,STREAM,GAP}, result record struct {score,id,len}.
//  - Sub-module sw_sync_fifo (#WIDTH,#DEPTH; push/pop/full/empty, async active-high rst),
//    instantiated twice: meta FIFO and result FIFO. Top holds FSM, counters, credits.
// TESTING
//  1. Reset, send "ACGT" (last on T), r_ready=1 -> arr_data 00,11,01,10 with arr_counter 0..3 on
//     consecutive cycles, 1 cycle after acceptance; arr_en low GAP_CYCLES cycles after.
//  2. Model arr_vld with arr_result=-2048+9 -> r_score=9, r_id=0, r_len=4; busy falls after pop.
//  3. r_ready=0, push 5 sequences (RES_DEPTH=4) -> 5th first base stalls (s_ready=0) until one pop,
//     then proceeds; r_id order 0,1,2,3,4.
//  4. Single-base sequence "G" with s_last -> one arr_en pulse, arr_counter=0, r_len=1.
//  5. arr_vld pulse with nothing in flight -> err=1 and stays 1, r_valid stays 0.
//  6. Assert rst after 3 bases of a 10-base sequence -> all outputs 0 next cycle; new sequence
//     after release gets r_id=0, arr_counter restarts at 0.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared types for the Smith-Waterman stream scheduler.
// Base codes, scheduler states and the result record.
package sw_pkg;
  localparam int SW_SCORE_WIDTH = 12;
  localparam int SW_CNT_WIDTH   = 12;
  localparam int SW_ID_WIDTH    = 8;
  localparam int SW_ZERO        = 2 ** (SW_SCORE_WIDTH - 1);

  typedef enum logic [1:0] {
    BASE_A = 2'b00,
    BASE_G = 2'b01,
    BASE_T = 2'b10,
    BASE_C = 2'b11
  } base_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_GAP
  } sched_state_t;

  typedef struct packed {
    logic [SW_SCORE_WIDTH-1:0] score;
    logic [SW_ID_WIDTH-1:0]    id;
    logic [SW_CNT_WIDTH-1:0]   len;
  } sw_result_t;
endpackage

// File: rtl/sw_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers.
// Push when full and pop when empty are ignored.
module sw_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem[rd_q[AW-1:0]];

  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    wr_d    = do_push ? wr_q + (AW+1)'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + (AW+1)'(1) : rd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/sw_stream_scheduler.sv
// Feeds database bases into the scoring array and pairs
// each array result with its sequence tag and length.
module sw_stream_scheduler
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = SW_SCORE_WIDTH,
  parameter int CNT_WIDTH   = SW_CNT_WIDTH,
  parameter int ID_WIDTH    = SW_ID_WIDTH,
  parameter int RES_DEPTH   = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             s_base,
  input  logic                   s_last,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   arr_en,
  output logic [1:0]             arr_data,
  output logic [CNT_WIDTH-1:0]   arr_counter,
  input  logic                   arr_vld,
  input  logic [SCORE_WIDTH-1:0] arr_result,
  output logic                   r_valid,
  input  logic                   r_ready,
  output logic [SCORE_WIDTH-1:0] r_score,
  output logic [ID_WIDTH-1:0]    r_id,
  output logic [CNT_WIDTH-1:0]   r_len,
  output logic                   busy,
  output logic                   err
);
  localparam int CRW = $clog2(RES_DEPTH + 1);
  localparam int GW  = $clog2(GAP_CYCLES + 1);
  localparam int MW  = ID_WIDTH + CNT_WIDTH;
  localparam int RW  = SCORE_WIDTH + MW;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CRW-1:0] CR_FULL = CRW'(RES_DEPTH);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [SCORE_WIDTH-1:0] ZERO =
    {1'b1, {(SCORE_WIDTH-1){1'b0}}};

  sched_state_t state_q, state_d;
  logic [CRW-1:0] credits_q, credits_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d, idx_cur, idx_inc;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [GW-1:0] gap_q, gap_d;
  logic err_q, err_d;
  logic en_q, en_d;
  logic [1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic accept, consume;
  logic meta_push, meta_pop, meta_full, meta_empty;
  logic res_push, res_pop, res_full, res_empty;
  logic [MW-1:0] meta_din, meta_dout;
  logic [RW-1:0] res_din, res_dout;

  always_comb begin
    s_ready = 1'b0;
    unique case (state_q)
      S_IDLE:   s_ready = (credits_q != '0);
      S_STREAM: s_ready = 1'b1;
      default:  s_ready = 1'b0;
    endcase
    if (rst) s_ready = 1'b0;
  end

  always_comb begin
    accept  = s_valid & s_ready;
    consume = accept & (state_q == S_IDLE);
    idx_cur = (state_q == S_IDLE) ? '0 : idx_q;
    idx_inc = (idx_cur == CNT_MAX) ? idx_cur
                                   : idx_cur + CNT_WIDTH'(1);
    state_d = state_q;
    idx_d   = idx_q;
    id_d    = id_q;
    gap_d   = gap_q;
    en_d    = accept;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (accept) begin
      data_d = s_base;
      cnt_d  = idx_cur;
      idx_d  = idx_inc;
    end
    if (accept & s_last) id_d = id_q + ID_WIDTH'(1);
    unique case (state_q)
      S_IDLE:
        if (accept) state_d = s_last ? S_GAP : S_STREAM;
      S_STREAM:
        if (accept & s_last) state_d = S_GAP;
      default: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end
      end
    endcase
    // Length of the finished sequence is the saturated next index
    meta_push = accept & s_last & ~meta_full;
    meta_din  = {id_q, idx_inc};
    meta_pop  = arr_vld & ~meta_empty;
    res_push  = meta_pop & ~res_full;
    res_din   = {arr_result + ZERO, meta_dout};
    err_d     = err_q | (arr_vld & meta_empty);
    res_pop   = ~res_empty & r_ready;
    credits_d = credits_q - CRW'(consume) + CRW'(res_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      credits_q <= CR_FULL;
      idx_q     <= '0;
      id_q      <= '0;
      gap_q     <= '0;
      err_q     <= 1'b0;
      en_q      <= 1'b0;
      data_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      idx_q     <= idx_d;
      id_q      <= id_d;
      gap_q     <= gap_d;
      err_q     <= err_d;
      en_q      <= en_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
    end
  end

  sw_sync_fifo #(.WIDTH(MW), .DEPTH(RES_DEPTH)) u_meta (
    .clk   (clk),
    .rst   (rst),
    .push  (meta_push),
    .din   (meta_din),
    .pop   (meta_pop),
    .dout  (meta_dout),
    .full  (meta_full),
    .empty (meta_empty)
  );

  sw_sync_fifo #(.WIDTH(RW), .DEPTH(RES_DEPTH)) u_res (
    .clk   (clk),
    .rst   (rst),
    .push  (res_push),
    .din   (res_din),
    .pop   (res_pop),
    .dout  (res_dout),
    .full  (res_full),
    .empty (res_empty)
  );

  assign arr_en      = en_q;
  assign arr_data    = data_q;
  assign arr_counter = cnt_q;
  assign r_valid     = ~res_empty;
  assign {r_score, r_id, r_len} = r_valid ? res_dout : '0;
  assign busy = (state_q != S_IDLE) | (credits_q != CR_FULL);
  assign err  = err_q;
endmodule

// File: tb/tb_sw_stream_scheduler.sv
// Randomized bench for sw_stream_scheduler with a queue-based
// model of sequence tagging, result pairing and credits.
module tb_sw_stream_scheduler;
  import sw_pkg::*;

  localparam int SW   = 12;
  localparam int CW   = 12;
  localparam int IW   = 8;
  localparam int DEP  = 4;
  localparam int GAPC = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] s_base = '0;
  logic s_last = 1'b0, s_valid = 1'b0, s_ready;
  logic arr_en;
  logic [1:0] arr_data;
  logic [CW-1:0] arr_counter;
  logic arr_vld = 1'b0;
  logic [SW-1:0] arr_result = '0;
  logic r_valid, r_ready = 1'b0;
  logic [SW-1:0] r_score;
  logic [IW-1:0] r_id;
  logic [CW-1:0] r_len;
  logic busy, err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int cyc;
    logic [1:0] d;
    logic [CW-1:0] c;
  } obs_t;
  obs_t obs_q[$];
  int acc_q[$];

  int exp_id[$], exp_len[$];
  int res_score[$], res_id[$], res_len[$];
  int model_next_id = 0;
  bit model_err = 0;

  sw_stream_scheduler #(
    .SCORE_WIDTH(SW), .CNT_WIDTH(CW), .ID_WIDTH(IW),
    .RES_DEPTH(DEP), .GAP_CYCLES(GAPC)
  ) dut (
    .clk(clk), .rst(rst),
    .s_base(s_base), .s_last(s_last),
    .s_valid(s_valid), .s_ready(s_ready),
    .arr_en(arr_en), .arr_data(arr_data),
    .arr_counter(arr_counter),
    .arr_vld(arr_vld), .arr_result(arr_result),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_score(r_score), .r_id(r_id), .r_len(r_len),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (arr_en === 1'b1)
      obs_q.push_back('{cyc, arr_data, arr_counter});

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_seq(input logic [1:0] b[$],
                           input int bub, output bit to);
    int i, w;
    i = 0;
    to = 0;
    while (i < b.size()) begin
      @(negedge clk);
      if (bub > 0 && $urandom_range(99) < bub) begin
        s_valid = 0;
        s_last = 0;
      end else begin
        s_valid = 1;
        s_base = b[i];
        s_last = (i == b.size() - 1);
        #1;
        w = 0;
        while (!s_ready && w < 200) begin
          @(negedge clk);
          #1;
          w++;
        end
        if (!s_ready) begin
          to = 1;
          s_valid = 0;
          s_last = 0;
          return;
        end
        acc_q.push_back(cyc + 1);
        i++;
      end
    end
    @(negedge clk);
    s_valid = 0;
    s_last = 0;
    exp_id.push_back(model_next_id);
    exp_len.push_back(b.size());
    model_next_id = (model_next_id + 1) % 256;
  endtask

  task automatic pulse_vld(input logic [SW-1:0] r);
    @(negedge clk);
    arr_vld = 1;
    arr_result = r;
    @(negedge clk);
    arr_vld = 0;
    if (exp_id.size() > 0) begin
      res_id.push_back(exp_id.pop_front());
      res_len.push_back(exp_len.pop_front());
      res_score.push_back((int'(r) + SW_ZERO) % 4096);
    end else begin
      model_err = 1;
    end
  endtask

  task automatic pop_one();
    @(negedge clk);
    r_ready = 1;
    @(negedge clk);
    r_ready = 0;
    if (res_id.size() > 0) begin
      void'(res_id.pop_front());
      void'(res_len.pop_front());
      void'(res_score.pop_front());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    s_valid = 0;
    s_last = 0;
    r_ready = 0;
    arr_vld = 0;
    @(negedge clk);
    rst = 0;
    exp_id.delete();
    exp_len.delete();
    res_id.delete();
    res_len.delete();
    res_score.delete();
    model_next_id = 0;
    model_err = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({s_ready, arr_en, arr_data, arr_counter, r_valid,
         r_score, r_id, r_len, busy, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outs: got s_ready=%b en=%b cnt=%h rv=%b busy=%b err=%b want all 0",
               s_ready, arr_en, arr_counter, r_valid, busy, err);
    end
    rst = 0;
    #1;
    vectors++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got s_ready=%b busy=%b want 1 0",
               s_ready, busy);
    end
  endtask

  task automatic test_acgt();
    logic [1:0] b[$];
    bit to;
    b = '{2'b00, 2'b11, 2'b01, 2'b10};
    obs_q.delete();
    acc_q.delete();
    r_ready = 0;
    drive_seq(b, 0, to);
    repeat (3) @(negedge clk);
    vectors++;
    if (to || obs_q.size() != 4) begin
      miscompares++;
      $display("FAIL acgt_count: got %0d beats to=%0d want 4",
               obs_q.size(), to);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (obs_q[i].d !== b[i] || obs_q[i].c !== CW'(i) ||
            obs_q[i].cyc != acc_q[i] ||
            obs_q[i].cyc != obs_q[0].cyc + i) begin
          miscompares++;
          $display("FAIL acgt_beat%0d: got d=%b c=%0d cyc=%0d want d=%b c=%0d cyc=%0d",
                   i, obs_q[i].d, obs_q[i].c, obs_q[i].cyc,
                   b[i], i, acc_q[i]);
        end
      end
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL acgt_busy: got %b want 1", busy);
    end
    pulse_vld(12'h809);
    vectors++;
    if (r_valid !== 1'b1 || r_score !== SW'(res_score[0]) ||
        r_score !== SW'(9) || r_id !== IW'(res_id[0]) ||
        r_len !== CW'(res_len[0])) begin
      miscompares++;
      $display("FAIL acgt_result: got v=%b s=%0d id=%0d len=%0d want 1 9 0 4",
               r_valid, r_score, r_id, r_len);
    end
    pop_one();
    vectors++;
    if (busy !== 1'b0 || r_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL acgt_after_pop: got busy=%b rv=%b want 0 0",
               busy, r_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] a[$], c[$];
    bit to1, to2;
    int na, k;
    na = $urandom_range(2, 6);
    for (int i = 0; i < na; i++) a.push_back(2'($urandom));
    for (int i = 0; i < 3; i++) c.push_back(2'($urandom));
    obs_q.delete();
    acc_q.delete();
    drive_seq(a, 0, to1);
    drive_seq(c, 0, to2);
    repeat (3) @(negedge clk);
    vectors++;
    if (to1 || to2 || obs_q.size() != na + 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d want %0d",
               obs_q.size(), na + 3);
    end else begin
      vectors++;
      if (obs_q[na].cyc - obs_q[na-1].cyc != GAPC + 1) begin
        miscompares++;
        $display("FAIL b2b_gap: got %0d want %0d",
                 obs_q[na].cyc - obs_q[na-1].cyc, GAPC + 1);
      end
      for (int i = 0; i < na + 3; i++) begin
        k = (i < na) ? i : i - na;
        vectors++;
        if (obs_q[i].d !== ((i < na) ? a[k] : c[k]) ||
            obs_q[i].c !== CW'(k)) begin
          miscompares++;
          $display("FAIL b2b_beat%0d: got d=%b c=%0d want c=%0d",
                   i, obs_q[i].d, obs_q[i].c, k);
        end
      end
    end
    pulse_vld(SW'($urandom));
    pulse_vld(SW'($urandom));
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (r_valid !== 1'b1 || r_score !== SW'(res_score[0]) ||
          r_id !== IW'(res_id[0]) || r_len !== CW'(res_len[0])) begin
        miscompares++;
        $display("FAIL b2b_res%0d: got s=%0d id=%0d len=%0d want %0d %0d %0d",
                 i, r_score, r_id, r_len,
                 res_score[0], res_id[0], res_len[0]);
      end
      pop_one();
    end
  endtask

  task automatic test_credit_stall();
    logic [1:0] b[$];
    logic [1:0] b5[$];
    bit to, to5;
    bit stalled;
    int pop_cyc, n;
    do_reset();
    r_ready = 0;
    for (int k = 0; k < DEP; k++) begin
      b.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) b.push_back(2'($urandom));
      drive_seq(b, 0, to);
      vectors++;
      if (to) begin
        miscompares++;
        $display("FAIL credit_seq%0d: timeout want accepted", k);
      end
      pulse_vld(SW'($urandom));
    end
    b5 = '{2'b01, 2'b10};
    acc_q.delete();
    stalled = 1;
    pop_cyc = 0;
    fork
      drive_seq(b5, 0, to5);
      begin
        repeat (8) begin
          @(negedge clk);
          #1;
          if (s_ready !== 1'b0 || acc_q.size() != 0) stalled = 0;
        end
        @(negedge clk);
        r_ready = 1;
        pop_cyc = cyc + 1;
        @(negedge clk);
        r_ready = 0;
      end
    join
    void'(res_id.pop_front());
    void'(res_len.pop_front());
    void'(res_score.pop_front());
    vectors++;
    if (!stalled) begin
      miscompares++;
      $display("FAIL credit_stall: got accept while full want stall");
    end
    vectors++;
    if (to5 || acc_q.size() == 0 || acc_q[0] <= pop_cyc) begin
      miscompares++;
      $display("FAIL credit_resume: got acc=%0d pop=%0d to=%0d want acc>pop",
               (acc_q.size() > 0) ? acc_q[0] : -1, pop_cyc, to5);
    end
    pulse_vld(SW'($urandom));
    for (int k = 1; k <= DEP; k++) begin
      vectors++;
      if (r_valid !== 1'b1 || r_id !== IW'(k) ||
          r_id !== IW'(res_id[0]) || r_len !== CW'(res_len[0]) ||
          r_score !== SW'(res_score[0])) begin
        miscompares++;
        $display("FAIL credit_order%0d: got id=%0d len=%0d s=%0d want %0d %0d %0d",
                 k, r_id, r_len, r_score, k, res_len[0], res_score[0]);
      end
      pop_one();
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL credit_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_single_base();
    logic [1:0] b[$];
    bit to;
    b = '{2'b01};
    obs_q.delete();
    drive_seq(b, 0, to);
    repeat (3) @(negedge clk);
    vectors++;
    if (to || obs_q.size() != 1 || obs_q[0].d !== 2'b01 ||
        obs_q[0].c !== '0) begin
      miscompares++;
      $display("FAIL single_beat: got n=%0d want one G at 0",
               obs_q.size());
    end
    pulse_vld(SW'($urandom));
    vectors++;
    if (r_valid !== 1'b1 || r_len !== CW'(1) ||
        r_id !== IW'(res_id[0]) || r_score !== SW'(res_score[0])) begin
      miscompares++;
      $display("FAIL single_result: got v=%b len=%0d id=%0d want 1 1 %0d",
               r_valid, r_len, r_id, res_id[0]);
    end
    pop_one();
  endtask

  task automatic test_err();
    vectors++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL err_pre: got err=%b busy=%b want 0 0", err, busy);
    end
    pulse_vld(SW'($urandom));
    vectors++;
    if (err !== model_err || r_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL err_set: got err=%b rv=%b want %b 0",
               err, r_valid, model_err);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (err !== 1'b1 || r_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL err_sticky: got err=%b rv=%b want 1 0",
               err, r_valid);
    end
  endtask

  task automatic test_rst_mid();
    logic [1:0] b[$];
    bit to;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_valid = 1;
      s_base = 2'($urandom);
      s_last = 0;
    end
    @(negedge clk);
    s_valid = 0;
    rst = 1;
    #1;
    vectors++;
    if ({s_ready, arr_en, arr_data, arr_counter, r_valid,
         r_score, r_id, r_len, busy, err} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_async: got en=%b cnt=%0d busy=%b err=%b want all 0",
               arr_en, arr_counter, busy, err);
    end
    @(negedge clk);
    vectors++;
    if ({s_ready, arr_en, arr_data, arr_counter, r_valid,
         r_score, r_id, r_len, busy, err} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_hold: got en=%b busy=%b err=%b want all 0",
               arr_en, busy, err);
    end
    rst = 0;
    exp_id.delete();
    exp_len.delete();
    res_id.delete();
    res_len.delete();
    res_score.delete();
    model_next_id = 0;
    model_err = 0;
    b = '{2'b11, 2'b00, 2'b10};
    obs_q.delete();
    drive_seq(b, 0, to);
    repeat (3) @(negedge clk);
    vectors++;
    if (to || obs_q.size() != 3) begin
      miscompares++;
      $display("FAIL rst_new_count: got %0d want 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (obs_q[i].c !== CW'(i) || obs_q[i].d !== b[i]) begin
          miscompares++;
          $display("FAIL rst_new_beat%0d: got c=%0d d=%b want %0d %b",
                   i, obs_q[i].c, obs_q[i].d, i, b[i]);
        end
      end
    end
    pulse_vld(SW'($urandom));
    vectors++;
    if (r_valid !== 1'b1 || r_id !== '0 || r_len !== CW'(3) ||
        r_score !== SW'(res_score[0]) || err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_new_result: got id=%0d len=%0d err=%b want 0 3 0",
               r_id, r_len, err);
    end
    pop_one();
  endtask

  task automatic test_random();
    logic [1:0] b[$];
    logic [1:0] eb[$];
    int ec[$];
    bit to;
    int k, n;
    for (int it = 0; it < 15; it++) begin
      obs_q.delete();
      eb.delete();
      ec.delete();
      k = $urandom_range(1, 3);
      for (int s = 0; s < k; s++) begin
        b.delete();
        n = $urandom_range(1, 10);
        for (int i = 0; i < n; i++) begin
          b.push_back(2'($urandom));
          eb.push_back(b[i]);
          ec.push_back(i);
        end
        drive_seq(b, 25, to);
        vectors++;
        if (to) begin
          miscompares++;
          $display("FAIL rand_drive%0d: timeout want accepted", it);
        end
      end
      repeat (2) @(negedge clk);
      vectors++;
      if (obs_q.size() != eb.size()) begin
        miscompares++;
        $display("FAIL rand_count%0d: got %0d want %0d",
                 it, obs_q.size(), eb.size());
      end else begin
        for (int i = 0; i < eb.size(); i++) begin
          vectors++;
          if (obs_q[i].d !== eb[i] || obs_q[i].c !== CW'(ec[i])) begin
            miscompares++;
            $display("FAIL rand_beat%0d_%0d: got d=%b c=%0d want %b %0d",
                     it, i, obs_q[i].d, obs_q[i].c, eb[i], ec[i]);
          end
        end
      end
      for (int s = 0; s < k; s++) pulse_vld(SW'($urandom));
      for (int s = 0; s < k; s++) begin
        vectors++;
        if (r_valid !== 1'b1 || r_score !== SW'(res_score[0]) ||
            r_id !== IW'(res_id[0]) || r_len !== CW'(res_len[0])) begin
          miscompares++;
          $display("FAIL rand_res%0d_%0d: got s=%0d id=%0d len=%0d want %0d %0d %0d",
                   it, s, r_score, r_id, r_len,
                   res_score[0], res_id[0], res_len[0]);
        end
        pop_one();
      end
      vectors++;
      if (busy !== 1'b0 || r_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_idle%0d: got busy=%b rv=%b want 0 0",
                 it, busy, r_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_acgt();
    test_back_to_back();
    test_credit_stall();
    test_single_base();
    test_err();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
